// File: rtl/dmem_pkg.sv
// Shared widths, FSM state encoding and port indices for the data-memory arbiter.
// No logic of its own; zero latency, no backpressure.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the data-memory pins; master = requesters/memory, slave = arbiter.
// Pure wiring: no latency, handshake semantics are defined by the arbiter.
interface dmem_arbiter_if #(
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int ADDR_W = dmem_pkg::ADDR_W
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rd,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_we, mem_wd
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rd,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_we, mem_wd
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational two-way pick: port 0 wins a tie unless last_grant says port 0 went last.
// Zero latency, stateless; backpressure is applied by the caller.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = valid0 && !(valid1 && (last_grant == PORT_CPU));
        grant1 = valid1 && !grant0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a 1-cycle-latency sync data memory between CPU (port 0) and debug/DMA (port 1); DMEM_ARB_ROUND_ROBIN_EN selects round-robin, else port 0 priority.
// Stores retire at the grant edge; load rsp pulses 2 cycles after grant; both readies drop during RD_WAIT, requesters hold until ready.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic              last_grant;
    logic              pick0, pick1;
    logic              grant0, grant1;
    logic              sel, sel_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    // Pinning last_grant to port 1 makes the picker resolve every tie to port 0.
    assign last_grant = PORT_DBG;
`endif

    dmem_arb_pick u_pick (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .grant0     (pick0),
        .grant1     (pick1)
    );

    assign grant0 = pick0 && (state_q == ST_IDLE) && !reset;
    assign grant1 = pick1 && (state_q == ST_IDLE) && !reset;
    assign sel    = grant1 ? PORT_DBG : PORT_CPU;
    assign sel_we = sel ? bus.req1_we : bus.req0_we;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wd       = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        if (grant0 || grant1) begin
            mem_addr = sel ? bus.req1_addr  : bus.req0_addr;
            mem_wd   = sel ? bus.req1_wdata : bus.req0_wdata;
            mem_we   = sel_we;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_d = sel;
`endif
            if (!sel_we) begin
                state_d = ST_RD_WAIT;
                owner_d = sel;
            end
        end
        // mem_rd holds the granted word during RD_WAIT; steer it to the port that asked.
        if (state_q == ST_RD_WAIT) begin
            state_d = ST_IDLE;
            if (owner_q == PORT_DBG) begin
                rsp1_valid_d = 1'b1;
                rsp1_rdata_d = bus.mem_rd;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_rdata_d = bus.mem_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_CPU;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= PORT_DBG;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_we     = mem_we;
    assign bus.mem_wd     = mem_wd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked against a transaction-level model
// (reference memory, pending-response list, one blocked slot after each load, tie policy from DMEM_ARB_ROUND_ROBIN_EN).
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    // External single-port sync memory driven only by the arbiter pins.
    logic [31:0] tb_mem [32];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
        end else if (bus.mem_we) begin
            tb_mem[bus.mem_addr] <= bus.mem_wd;
        end
        bus.mem_rd <= tb_mem[bus.mem_addr];
    end

    typedef struct {
        int          at;
        logic        port;
        logic [31:0] data;
    } exp_rsp_t;

    logic [31:0] ref_mem [32];
    exp_rsp_t    pend [$];
    int          cyc, blocked;
    logic        rr_last, rst_prev;
    logic        gnt0, gnt1;
    int          n_cmp, n_err;
    int          dut_g0, dut_g1, rsp0_cnt, rsp1_cnt;
    logic [31:0] last_rsp0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check at the falling edge, advance the model, step past the rising edge.
    task automatic step();
        logic        v0, v1, g, win, we, e0, e1;
        logic [4:0]  a;
        logic [31:0] wd, d0, d1;
        exp_rsp_t    e;
        @(negedge clk);
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        g = 1'b0;
        win = 1'b0;
        if (!reset && cyc != blocked && (v0 || v1)) begin
            g = 1'b1;
            if (v0 && v1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                win = ~rr_last;
`else
                win = 1'b0;
`endif
            end else begin
                win = v1;
            end
        end
        we = win ? bus.req1_we    : bus.req0_we;
        a  = win ? bus.req1_addr  : bus.req0_addr;
        wd = win ? bus.req1_wdata : bus.req0_wdata;

        chk("req0_ready", 32'(bus.req0_ready), 32'(g && !win));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g && win));
        chk("mem_we", 32'(bus.mem_we), 32'(g && we));
        if (g) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(a));
            if (we) chk("mem_wd", bus.mem_wd, wd);
        end
        if (reset) begin
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_mem_wd", bus.mem_wd, 32'd0);
        end

        e0 = 1'b0; e1 = 1'b0; d0 = '0; d1 = '0;
        foreach (pend[i]) begin
            if (pend[i].at == cyc) begin
                if (pend[i].port) begin e1 = 1'b1; d1 = pend[i].data; end
                else              begin e0 = 1'b1; d0 = pend[i].data; end
            end
        end
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e1));
        if (e0) chk("rsp0_rdata", bus.rsp0_rdata, d0);
        if (e1) chk("rsp1_rdata", bus.rsp1_rdata, d1);
        if (rst_prev) begin
            chk("rst_rsp0_rdata", bus.rsp0_rdata, 32'd0);
            chk("rst_rsp1_rdata", bus.rsp1_rdata, 32'd0);
        end

        if (bus.req0_ready) dut_g0++;
        if (bus.req1_ready) dut_g1++;
        if (bus.rsp0_valid) begin rsp0_cnt++; last_rsp0 = bus.rsp0_rdata; end
        if (bus.rsp1_valid) rsp1_cnt++;

        if (reset) begin
            pend.delete();
            blocked = -1;
            rr_last = 1'b1;
        end else begin
            while (pend.size() > 0 && pend[0].at <= cyc) pend.delete(0);
            if (g) begin
                rr_last = win;
                if (we) begin
                    ref_mem[a] = wd;
                end else begin
                    e.at = cyc + 2;
                    e.port = win;
                    e.data = ref_mem[a];
                    pend.push_back(e);
                    blocked = cyc + 1;
                end
            end
        end
        gnt0 = g && !win;
        gnt1 = g && win;
        rst_prev = reset;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_all();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; blocked = -1; rr_last = 1'b1; rst_prev = 1'b0;
        gnt0 = 1'b0; gnt1 = 1'b0;
        dut_g0 = 0; dut_g1 = 0; rsp0_cnt = 0; rsp1_cnt = 0; last_rsp0 = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        idle_all();
        reset = 1'b1;
        mem_init = 1'b1;
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst_prev = 1'b1;
        cyc = 1;

        // Reset held with both ports requesting.
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd4;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6;
        repeat (3) step();

        // Port 0 store then load of the same word.
        reset = 1'b0;
        idle_all();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 5'd5; bus.req0_wdata = 32'hDEAD_BEEF;
        step();
        bus.req0_we = 1'b0;
        rsp0_cnt = 0; rsp1_cnt = 0;
        step();
        idle_all();
        repeat (3) step();
        chk("t2_rsp0_count", 32'(rsp0_cnt), 32'd1);
        chk("t2_rsp0_rdata", last_rsp0, 32'hDEAD_BEEF);
        chk("t2_rsp1_count", 32'(rsp1_cnt), 32'd0);

        // Continuous contention on loads from both ports.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd1;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd2;
        dut_g0 = 0; dut_g1 = 0;
        repeat (8) step();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        chk("t3_p0_grants", 32'(dut_g0), 32'd2);
        chk("t3_p1_grants", 32'(dut_g1), 32'd2);
`else
        chk("t3_p0_grants", 32'(dut_g0), 32'd4);
        chk("t3_p1_grants", 32'(dut_g1), 32'd0);
`endif
        idle_all();
        repeat (3) step();

        // Port 1 back-to-back stores.
        dut_g1 = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req1_valid = 1'b1; bus.req1_we = 1'b1;
            bus.req1_addr = 5'(i); bus.req1_wdata = 32'hCAFE_0000 + 32'(i);
            step();
        end
        chk("t4_p1_grants", 32'(dut_g1), 32'd4);
        for (int i = 0; i < 4; i++) chk("t4_mem_word", tb_mem[i], 32'hCAFE_0000 + 32'(i));
        idle_all();
        step();

        // Reset during RD_WAIT drops the response; arbiter is idle right after.
        rsp0_cnt = 0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7;
        step();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7;
        step();
        idle_all();
        repeat (2) step();
        chk("t5_rsp0_count", 32'(rsp0_cnt), 32'd1);

        // Port 0 store withdrawn while port 1 owns RD_WAIT.
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd9;
        step();
        idle_all();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 5'd3; bus.req0_wdata = 32'h1111_2222;
        step();
        idle_all();
        repeat (3) step();
        chk("t6_mem_untouched", tb_mem[3], 32'hCAFE_0003);

        // Random traffic with holds, withdrawals and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if (gnt0 || !bus.req0_valid) begin
                if ($urandom_range(0, 9) < 6) begin
                    bus.req0_valid = 1'b1;
                    bus.req0_we    = 1'($urandom_range(0, 1));
                    bus.req0_addr  = 5'($urandom_range(0, 7));
                    bus.req0_wdata = $urandom;
                end else begin
                    bus.req0_valid = 1'b0;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (gnt1 || !bus.req1_valid) begin
                if ($urandom_range(0, 9) < 6) begin
                    bus.req1_valid = 1'b1;
                    bus.req1_we    = 1'($urandom_range(0, 1));
                    bus.req1_addr  = 5'($urandom_range(0, 7));
                    bus.req1_wdata = $urandom;
                end else begin
                    bus.req1_valid = 1'b0;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                bus.req1_valid = 1'b0;
            end
            reset = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0;
        idle_all();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
